// File: rtl/bitstream_byte_feeder.sv
// bitstream_byte_feeder: streaming slice-data source for the arithmetic decoder.
// Accepts producer bytes over valid/ready and removes emulation-prevention bytes
// (00 00 03 -> 00 00). The surviving bytes are buffered in a small FIFO, and the
// FIFO head is presented through the decoder's request/data/data_ready contract.
module bitstream_byte_feeder #(
  parameter int DEPTH_LOG2 = 2,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  input  logic             in_last,
  output logic             in_ready,
  input  logic             request,
  output logic [7:0]       data,
  output logic             data_ready,
  output logic             eos,
  output logic             underrun,
  output logic [CNT_W-1:0] epb_count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DepthCount = (DEPTH_LOG2 + 1)'(DEPTH);

  // Number of consecutive zero bytes accepted, capped at two.
  typedef enum logic [1:0] {
    ZR_NONE = 2'd0,
    ZR_ONE  = 2'd1,
    ZR_TWO  = 2'd2
  } zero_run_e;

  logic [7:0]            mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  zero_run_e             zero_run_q, zero_run_d;
  logic                  last_seen_q, last_seen_d;
  logic                  underrun_q, underrun_d;
  logic [CNT_W-1:0]      epb_count_q, epb_count_d;

  logic accept;
  logic drop_epb;
  logic do_write;
  logic do_pop;
  logic fifo_empty;

  // State register; reset has the same effect as flush.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      zero_run_q  <= ZR_NONE;
      last_seen_q <= 1'b0;
      underrun_q  <= 1'b0;
      epb_count_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      zero_run_q  <= zero_run_d;
      last_seen_q <= last_seen_d;
      underrun_q  <= underrun_d;
      epb_count_q <= epb_count_d;
    end
  end

  // Byte storage; contents after flush or reset are never read, so no reset.
  always_ff @(posedge clk) begin
    if (do_write && !flush) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

  // Next-state: handshake, emulation-prevention stripping, FIFO bookkeeping.
  always_comb begin
    fifo_empty  = (count_q == '0);
    accept      = in_valid && in_ready;
    drop_epb    = accept && (in_data == 8'h03) && (zero_run_q == ZR_TWO);
    do_write    = accept && !drop_epb;
    do_pop      = request && !fifo_empty;

    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    zero_run_d  = zero_run_q;
    last_seen_d = last_seen_q;
    underrun_d  = underrun_q;
    epb_count_d = epb_count_q;

    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      zero_run_d  = ZR_NONE;
      last_seen_d = 1'b0;
      underrun_d  = 1'b0;
      epb_count_d = '0;
    end else begin
      if (accept) begin
        if (drop_epb) begin
          zero_run_d = ZR_NONE;
          if (epb_count_q != '1) begin
            epb_count_d = epb_count_q + CNT_W'(1);
          end
        end else if (in_data == 8'h00) begin
          zero_run_d = (zero_run_q == ZR_NONE) ? ZR_ONE : ZR_TWO;
        end else begin
          zero_run_d = ZR_NONE;
        end
        if (in_last) begin
          last_seen_d = 1'b1;
        end
      end

      if (do_write) begin
        wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
      end

      case ({do_write, do_pop})
        2'b10:   count_d = count_q + (DEPTH_LOG2 + 1)'(1);
        2'b01:   count_d = count_q - (DEPTH_LOG2 + 1)'(1);
        default: count_d = count_q;
      endcase

      if (request && fifo_empty && !last_seen_q) begin
        underrun_d = 1'b1;
      end
    end
  end

  // Outputs are decoded from registered state only.
  always_comb begin
    in_ready   = (count_q != DepthCount) && !last_seen_q;
    data       = (count_q != '0) ? mem_q[rd_ptr_q] : 8'h00;
    data_ready = (count_q != '0);
    eos        = last_seen_q && (count_q == '0);
    underrun   = underrun_q;
    epb_count  = epb_count_q;
  end

endmodule

// File: tb/tb_bitstream_byte_feeder.sv
// tb_bitstream_byte_feeder: scoreboard bench for the streaming byte feeder.
// A reference model strips emulation-prevention bytes as stimulus is driven and
// queues the surviving bytes; pops compare the DUT head against that queue.
module tb_bitstream_byte_feeder;

  localparam int DepthLog2 = 2;
  localparam int Depth     = 1 << DepthLog2;
  localparam int CntW      = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic            flush;
  logic            inValid;
  logic [7:0]      inData;
  logic            inLast;
  logic            inReady;
  logic            request;
  logic [7:0]      data;
  logic            dataReady;
  logic            eos;
  logic            underrun;
  logic [CntW-1:0] epbCount;

  int checkCount = 0;
  int failCount  = 0;

  logic [7:0] expQ[$];
  int         mZeroRun;
  bit         mLast;
  bit         mUnder;
  int         mEpb;

  bitstream_byte_feeder #(
    .DEPTH_LOG2(DepthLog2),
    .CNT_W     (CntW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (inValid),
    .in_data   (inData),
    .in_last   (inLast),
    .in_ready  (inReady),
    .request   (request),
    .data      (data),
    .data_ready(dataReady),
    .eos       (eos),
    .underrun  (underrun),
    .epb_count (epbCount)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Watchdog so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic modelClear();
    expQ.delete();
    mZeroRun = 0;
    mLast    = 1'b0;
    mUnder   = 1'b0;
    mEpb     = 0;
  endtask

  task automatic checkAll(input string tag);
    logic [7:0] expHead;
    expHead = (expQ.size() != 0) ? expQ[0] : 8'h00;
    checkOutput({tag, "_data"},      data,      expHead);
    checkOutput({tag, "_dataReady"}, dataReady, expQ.size() != 0);
    checkOutput({tag, "_inReady"},   inReady,   (expQ.size() != Depth) && !mLast);
    checkOutput({tag, "_eos"},       eos,       mLast && (expQ.size() == 0));
    checkOutput({tag, "_underrun"},  underrun,  mUnder);
    checkOutput({tag, "_epbCount"},  epbCount,  mEpb);
  endtask

  // One clock cycle: check outputs, drive inputs, advance the model. Entered and left at a negedge.
  task automatic applyStimulus(input bit v, input logic [7:0] b, input bit l, input bit r, input bit f,
                               output bit accepted);
    bit expReady;
    checkAll("cyc");
    expReady = (expQ.size() != Depth) && !mLast;
    inValid  = v;
    inData   = b;
    inLast   = l;
    request  = r;
    flush    = f;
    accepted = 1'b0;
    if (f) begin
      modelClear();
    end else begin
      if (r) begin
        if (expQ.size() > 0) begin
          checkOutput("pop_data", data, expQ.pop_front());
        end else if (!mLast) begin
          mUnder = 1'b1;
        end
      end
      if (v && expReady) begin
        accepted = 1'b1;
        if (b == 8'h03 && mZeroRun == 2) begin
          mZeroRun = 0;
          if (mEpb != 32'hFFFF) mEpb++;
        end else begin
          expQ.push_back(b);
          mZeroRun = (b == 8'h00) ? ((mZeroRun == 2) ? 2 : mZeroRun + 1) : 0;
        end
        if (l) mLast = 1'b1;
      end
    end
    @(posedge clk);
    @(negedge clk);
    inValid = 1'b0;
    inLast  = 1'b0;
    request = 1'b0;
    flush   = 1'b0;
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, acc);
  endtask

  task automatic doFlush();
    bit acc;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, acc);
  endtask

  // Retry a byte until accepted; optionally pop alongside whenever data is buffered.
  task automatic pushByte(input logic [7:0] b, input bit l, input bit popAlong);
    bit acc;
    acc = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) begin
      applyStimulus(1'b1, b, l, popAlong && (expQ.size() > 0), 1'b0, acc);
    end
    if (!acc) checkOutput("push_timeout", 0, 1);
  endtask

  task automatic drain();
    bit acc;
    for (int i = 0; i < 40 && expQ.size() > 0; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, acc);
    end
    if (expQ.size() != 0) checkOutput("drain_timeout", 0, 1);
  endtask

  initial begin
    bit         acc;
    int         idx;
    logic [7:0] epbStream[8];

    reset   = 1'b1;
    flush   = 1'b0;
    inValid = 1'b0;
    inData  = 8'h00;
    inLast  = 1'b0;
    request = 1'b0;
    modelClear();
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    checkAll("reset");
    reset = 1'b1;

    // Plain data: three bytes in, head visible, then three pops.
    pushByte(8'h11, 1'b0, 1'b0);
    pushByte(8'h22, 1'b0, 1'b0);
    pushByte(8'h33, 1'b0, 1'b0);
    checkOutput("plain_head", data, 8'h11);
    checkOutput("plain_inReady", inReady, 1);
    drain();
    checkOutput("plain_emptyData", data, 8'h00);
    checkOutput("plain_emptyReady", dataReady, 0);

    // Emulation-prevention stripping with concurrent pops.
    doFlush();
    epbStream = '{8'h00, 8'h00, 8'h03, 8'h01, 8'h00, 8'h00, 8'h03, 8'h03};
    for (int i = 0; i < 8; i++) pushByte(epbStream[i], 1'b0, 1'b1);
    checkOutput("epb_count", epbCount, 2);
    drain();

    // Full FIFO blocks input, then pop-while-push across a pointer wrap.
    doFlush();
    for (int i = 0; i < Depth; i++) pushByte(8'hA0 + 8'(i), 1'b0, 1'b0);
    checkOutput("full_inReady", inReady, 0);
    applyStimulus(1'b1, 8'hA4, 1'b0, 1'b0, 1'b0, acc);
    idx = 4;
    for (int i = 0; i < 20 && idx < 6; i++) begin
      applyStimulus(1'b1, 8'hA0 + 8'(idx), 1'b0, 1'b1, 1'b0, acc);
      if (acc) idx++;
    end
    checkOutput("wrap_allPushed", idx, 6);
    drain();

    // Simultaneous push and pop at occupancy two.
    doFlush();
    pushByte(8'h41, 1'b0, 1'b0);
    pushByte(8'h42, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h43, 1'b0, 1'b1, 1'b0, acc);
    checkOutput("pp_head", data, 8'h42);
    drain();

    // End of slice: trailing requests after the last byte raise no underrun.
    doFlush();
    pushByte(8'hAA, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, acc);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, acc);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, acc);
    checkOutput("eos_flag", eos, 1);
    checkOutput("eos_data", data, 8'h00);
    checkOutput("eos_underrun", underrun, 0);
    checkOutput("eos_inReady", inReady, 0);

    // Underrun: request on empty mid-slice is sticky until flush.
    doFlush();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, acc);
    idle(2);
    checkOutput("underrun_sticky", underrun, 1);
    doFlush();
    checkOutput("underrun_cleared", underrun, 0);

    // Flush wins over a same-cycle push and pop at occupancy three.
    pushByte(8'h00, 1'b0, 1'b0);
    pushByte(8'h00, 1'b0, 1'b0);
    pushByte(8'h03, 1'b0, 1'b0);
    pushByte(8'h77, 1'b0, 1'b0);
    checkOutput("coll_epbBefore", epbCount, 1);
    applyStimulus(1'b1, 8'h88, 1'b0, 1'b1, 1'b1, acc);
    checkOutput("coll_dataReady", dataReady, 0);
    checkOutput("coll_eos", eos, 0);
    checkOutput("coll_epb", epbCount, 0);
    checkOutput("coll_inReady", inReady, 1);

    // Asynchronous reset in the middle of a burst clears outputs before any edge.
    pushByte(8'h00, 1'b0, 1'b0);
    pushByte(8'h00, 1'b0, 1'b0);
    pushByte(8'h03, 1'b0, 1'b0);
    pushByte(8'h5A, 1'b0, 1'b0);
    #2 reset = 1'b0;
    #1;
    modelClear();
    checkAll("async");
    @(negedge clk);
    reset = 1'b1;
    pushByte(8'h66, 1'b0, 1'b0);
    drain();
    idle(1);

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
